data_mem_bridge: RTL and testbench

DATA_MEM_BRIDGE -- requirements
Module: data_mem_bridge

---
 rtl/data_mem_bridge_pkg.sv | 61 ++++++
 rtl/data_mem_bridge_align.sv | 52 +++++
 rtl/data_mem_bridge.sv | 127 ++++++++++++
 tb/tb_data_mem_bridge.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_bridge_pkg.sv
// Shared definitions for the core data-port to memory bridge.
// Optional build macro: MISALIGN_TRAP_EN (misaligned accesses trap instead of being force-aligned).
package data_mem_bridge_pkg;

    localparam int NUM_LANES = 4;
    localparam int LANE_W    = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2,
        DONE   = 2'd3
    } memBridgeState_e;

    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10
    } memSize_e;

    // One 32-bit bus word viewed as a word, two halves or four byte lanes.
    typedef union packed {
        logic [31:0]                        word;
        logic [1:0][15:0]                   half;
        logic [NUM_LANES-1:0][LANE_W-1:0]   lane;
    } dataBus_u;

    // Access captured when the core request is accepted.
    typedef struct packed {
        logic     we;
        memSize_e size;
        dataBus_u wdata;
    } mem_access_t;

    // Size code 11 has no meaning of its own and behaves as a word.
    function automatic memSize_e decode_size(input logic [1:0] ctrl);
        case (ctrl)
            2'b00:   return BYTE;
            2'b01:   return HALF;
            default: return WORD;
        endcase
    endfunction

    function automatic logic is_misaligned(input memSize_e sz, input logic [1:0] a);
        case (sz)
            HALF:    return a[0];
            WORD:    return |a;
            default: return 1'b0;
        endcase
    endfunction

    // Drop the low address bits that natural alignment says are zero.
    function automatic logic [1:0] align_lo(input memSize_e sz, input logic [1:0] a);
        case (sz)
            HALF:    return {a[1], 1'b0};
            WORD:    return 2'b00;
            default: return a;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_bridge_align.sv
// Byte-lane steering between the LSB-aligned core data and the 32-bit memory word.
module data_lane_align
    import data_mem_bridge_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  memSize_e    size,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_out
);

    dataBus_u                          wr_bus;
    dataBus_u                          rd_shift;
    logic [NUM_LANES-1:0]              lane_keep;
    logic [NUM_LANES-1:0][LANE_W-1:0]  rd_lanes;

    // Byte enables and write replication so every lane carries the right bytes.
    always_comb begin
        wr_bus.word = wdata;
        be          = 4'b1111;
        wdata_rep   = wr_bus.word;
        lane_keep   = 4'b1111;
        case (size)
            BYTE: begin
                be        = 4'b0001 << addr_lo;
                wdata_rep = {4{wr_bus.lane[0]}};
                lane_keep = 4'b0001;
            end
            HALF: begin
                be        = 4'b0011 << {addr_lo[1], 1'b0};
                wdata_rep = {2{wr_bus.half[0]}};
                lane_keep = 4'b0011;
            end
            default: ;
        endcase
    end

    // Bring the addressed bytes down to bit 0 before masking.
    always_comb begin
        rd_shift.word = rdata >> {addr_lo, 3'b000};
    end

    // Zero-fill every lane above the access size.
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        assign rd_lanes[i] = lane_keep[i] ? rd_shift.lane[i] : '0;
    end

    assign rdata_out = rd_lanes;

endmodule

// File: rtl/data_mem_bridge.sv
// Bridge from the core MA-stage load/store port to a req/gnt/rvalid memory port.
// Optional build macro: MISALIGN_TRAP_EN -- misaligned half/word accesses are not
// issued; they go straight to DONE with a one-cycle data_misalign pulse.
module data_mem_bridge
    import data_mem_bridge_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_en,
    input  logic              data_rd_en_ma,
    input  logic              data_wr_en_ma,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [31:0]       data_wr,
    input  logic [1:0]        data_rd_wr_ctrl,
    output logic              data_ready,
    output logic [31:0]       data_rd,
    output logic              data_misalign,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
);

    memBridgeState_e   state, state_nxt;
    mem_access_t       acc_q;
    logic [ADDR_W-1:0] addr_q;
    memSize_e          size_in;
    logic              req_in;
    logic              accept;
    logic              mis_in;
    logic [3:0]        be;
    logic [31:0]       wdata_rep;
    logic [31:0]       rdata_al;

    assign req_in  = data_rd_en_ma | data_wr_en_ma;
    assign size_in = decode_size(data_rd_wr_ctrl);
    assign accept  = (state == IDLE) && req_in;

`ifdef MISALIGN_TRAP_EN
    assign mis_in = is_misaligned(size_in, data_addr[1:0]);
`else
    assign mis_in = 1'b0;
`endif

    // State register; reset abandons any access in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state and handshake outputs.
    always_comb begin
        state_nxt  = state;
        data_ready = 1'b0;
        mem_req    = 1'b0;
        case (state)
            IDLE: begin
                data_ready = !req_in;
                if (req_in) state_nxt = mis_in ? DONE : REQ;
            end
            REQ: begin
                mem_req = 1'b1;
                if (mem_gnt) state_nxt = acc_q.we ? DONE : WAIT_R;
            end
            WAIT_R: begin
                if (mem_rvalid) state_nxt = DONE;
            end
            DONE: begin
                data_ready = 1'b1;
                if (clk_en) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Capture the access on acceptance; stores win when both enables are high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= '0;
            acc_q  <= '0;
        end else if (accept) begin
            addr_q        <= {data_addr[ADDR_W-1:2], align_lo(size_in, data_addr[1:0])};
            acc_q.we      <= data_wr_en_ma;
            acc_q.size    <= size_in;
            acc_q.wdata   <= data_wr;
        end
    end

    data_lane_align u_align (
        .addr_lo   (addr_q[1:0]),
        .size      (acc_q.size),
        .wdata     (acc_q.wdata.word),
        .rdata     (mem_rdata),
        .be        (be),
        .wdata_rep (wdata_rep),
        .rdata_out (rdata_al)
    );

    // Load data holds until the next load returns; a trapped access reads as zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                              data_rd <= '0;
        else if (state == WAIT_R && mem_rvalid) data_rd <= rdata_al;
        else if (accept && mis_in)            data_rd <= '0;
    end

`ifdef MISALIGN_TRAP_EN
    // One-cycle pulse, visible in the first DONE cycle of a trapped access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) data_misalign <= 1'b0;
        else     data_misalign <= accept && mis_in;
    end
`else
    assign data_misalign = 1'b0;
`endif

    assign mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
    assign mem_we    = mem_req & acc_q.we;
    assign mem_be    = mem_req ? be : 4'b0000;
    assign mem_wdata = mem_req ? wdata_rep : 32'h0;

endmodule

// File: tb/tb_data_mem_bridge.sv
// Self-checking bench for data_mem_bridge: vector table plus hand sequences.
module tb_data_mem_bridge;

    logic        clk, rst, clk_en;
    logic        data_rd_en_ma, data_wr_en_ma;
    logic [31:0] data_addr, data_wr;
    logic [1:0]  data_rd_wr_ctrl;
    logic        data_ready, data_misalign;
    logic [31:0] data_rd;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    int checks = 0;
    int errors = 0;
    logic [31:0] last_rd = 32'h0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic        rd;
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          gnt_dly;
        int          rv_dly;
        logic [31:0] exp_maddr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[10];

    data_mem_bridge #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en),
        .data_rd_en_ma(data_rd_en_ma), .data_wr_en_ma(data_wr_en_ma),
        .data_addr(data_addr), .data_wr(data_wr), .data_rd_wr_ctrl(data_rd_wr_ctrl),
        .data_ready(data_ready), .data_rd(data_rd), .data_misalign(data_misalign),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic pop_chk(input string name);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty, got %h", name, data_rd);
        end else begin
            e = exp_q.pop_front();
            chk(name, data_rd, e);
            last_rd = e;
        end
    endtask

    // Drive one access through the bridge with the given grant/rvalid delays.
    task automatic run_vec(input vec_t v, input int idx);
        int cyc;
        @(negedge clk);
        data_rd_en_ma = v.rd; data_wr_en_ma = v.wr;
        data_addr = v.addr; data_rd_wr_ctrl = v.size; data_wr = v.wdata;
        #1 chk($sformatf("v%0d ready_low_on_accept", idx), {31'b0, data_ready}, 32'd0);
        cyc = 1;
        if (!v.wr) exp_q.push_back(v.exp_rd);
        @(negedge clk); cyc++;
        data_rd_en_ma = 1'b0; data_wr_en_ma = 1'b0;
        chk($sformatf("v%0d mem_req", idx), {31'b0, mem_req}, 32'd1);
        chk($sformatf("v%0d mem_addr", idx), mem_addr, v.exp_maddr);
        chk($sformatf("v%0d mem_be", idx), {28'b0, mem_be}, {28'b0, v.exp_be});
        chk($sformatf("v%0d mem_we", idx), {31'b0, mem_we}, {31'b0, v.wr});
        if (v.wr) chk($sformatf("v%0d mem_wdata", idx), mem_wdata, v.exp_wdata);
        for (int k = 0; k < v.gnt_dly; k++) begin
            @(negedge clk); cyc++;
            chk($sformatf("v%0d req_held", idx), {31'b0, mem_req}, 32'd1);
            chk($sformatf("v%0d addr_held", idx), mem_addr, v.exp_maddr);
            chk($sformatf("v%0d be_held", idx), {28'b0, mem_be}, {28'b0, v.exp_be});
            chk($sformatf("v%0d ready_low_req", idx), {31'b0, data_ready}, 32'd0);
        end
        mem_gnt = 1'b1;
        @(negedge clk); cyc++;
        mem_gnt = 1'b0;
        if (!v.wr) begin
            chk($sformatf("v%0d req_drop_wait", idx), {31'b0, mem_req}, 32'd0);
            for (int k = 0; k < v.rv_dly; k++) begin
                @(negedge clk); cyc++;
                chk($sformatf("v%0d ready_low_wait", idx), {31'b0, data_ready}, 32'd0);
            end
            mem_rvalid = 1'b1; mem_rdata = v.rdata;
            @(negedge clk); cyc++;
            mem_rvalid = 1'b0; mem_rdata = $urandom;
        end
        chk($sformatf("v%0d ready_done", idx), {31'b0, data_ready}, 32'd1);
        if (!v.wr) pop_chk($sformatf("v%0d data_rd", idx));
        else       chk($sformatf("v%0d data_rd_kept", idx), data_rd, last_rd);
        if (v.gnt_dly == 0 && v.rv_dly == 0)
            chk($sformatf("v%0d latency", idx), cyc, v.wr ? 32'd3 : 32'd4);
        @(negedge clk);
        chk($sformatf("v%0d idle_ready", idx), {31'b0, data_ready}, 32'd1);
    endtask

    initial begin
        vec_t mv;
        //          rd    wr    sz     addr        wdata         rdata         g  r  maddr       be       wdata_exp     rd_exp
        vecs[0] = '{1'b0, 1'b1, 2'b00, 32'h103, 32'h0000_00A5, 32'h0,        0, 0, 32'h100, 4'b1000, 32'hA5A5_A5A5, 32'h0};
        vecs[1] = '{1'b1, 1'b0, 2'b01, 32'h202, 32'h0,         32'h1234_ABCD, 0, 2, 32'h200, 4'b1100, 32'h0,         32'h0000_1234};
        vecs[2] = '{1'b1, 1'b0, 2'b10, 32'h300, 32'h0,         32'hDEAD_BEEF, 5, 0, 32'h300, 4'b1111, 32'h0,         32'hDEAD_BEEF};
        vecs[3] = '{1'b1, 1'b0, 2'b00, 32'h001, 32'h0,         32'h1122_3344, 0, 0, 32'h000, 4'b0010, 32'h0,         32'h0000_0033};
        vecs[4] = '{1'b0, 1'b1, 2'b01, 32'h042, 32'hFFFF_BEEF, 32'h0,        2, 0, 32'h040, 4'b1100, 32'hBEEF_BEEF, 32'h0};
        vecs[5] = '{1'b0, 1'b1, 2'b10, 32'h080, 32'hCAFE_F00D, 32'h0,        1, 0, 32'h080, 4'b1111, 32'hCAFE_F00D, 32'h0};
        vecs[6] = '{1'b1, 1'b0, 2'b00, 32'h203, 32'h0,         32'h89AB_CDEF, 0, 1, 32'h200, 4'b1000, 32'h0,         32'h0000_0089};
        vecs[7] = '{1'b1, 1'b0, 2'b11, 32'h010, 32'h0,         32'h1357_9BDF, 0, 0, 32'h010, 4'b1111, 32'h0,         32'h1357_9BDF};
        vecs[8] = '{1'b1, 1'b1, 2'b00, 32'h005, 32'h1234_567E, 32'h0,        0, 0, 32'h004, 4'b0010, 32'h7E7E_7E7E, 32'h0};
        vecs[9] = '{1'b1, 1'b0, 2'b01, 32'h000, 32'h0,         32'hFFFF_8001, 0, 0, 32'h000, 4'b0011, 32'h0,         32'h0000_8001};

        rst = 1'b1; clk_en = 1'b1;
        data_rd_en_ma = 1'b0; data_wr_en_ma = 1'b0;
        data_addr = 32'h0; data_wr = 32'h0; data_rd_wr_ctrl = 2'b00;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst data_ready", {31'b0, data_ready}, 32'd1);
        chk("rst mem_req", {31'b0, mem_req}, 32'd0);
        chk("rst mem_we", {31'b0, mem_we}, 32'd0);
        chk("rst mem_be", {28'b0, mem_be}, 32'd0);
        chk("rst mem_wdata", mem_wdata, 32'd0);
        chk("rst mem_addr", mem_addr, 32'd0);
        chk("rst data_rd", data_rd, 32'd0);
        chk("rst misalign", {31'b0, data_misalign}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

        // Misaligned word store to 0x6.
`ifdef MISALIGN_TRAP_EN
        @(negedge clk);
        data_wr_en_ma = 1'b1; data_addr = 32'h6; data_rd_wr_ctrl = 2'b10; data_wr = 32'h1111_2222;
        #1 chk("mis ready_low_on_accept", {31'b0, data_ready}, 32'd0);
        @(negedge clk);
        data_wr_en_ma = 1'b0;
        chk("mis no_req", {31'b0, mem_req}, 32'd0);
        chk("mis pulse", {31'b0, data_misalign}, 32'd1);
        chk("mis ready", {31'b0, data_ready}, 32'd1);
        chk("mis data_rd_zero", data_rd, 32'd0);
        last_rd = 32'h0;
        @(negedge clk);
        chk("mis pulse_end", {31'b0, data_misalign}, 32'd0);
        chk("mis no_req_after", {31'b0, mem_req}, 32'd0);
`else
        mv = '{1'b0, 1'b1, 2'b10, 32'h006, 32'h1111_2222, 32'h0, 0, 0, 32'h004, 4'b1111, 32'h1111_2222, 32'h0};
        run_vec(mv, 10);
        chk("mis never_pulses", {31'b0, data_misalign}, 32'd0);
        mv = '{1'b1, 1'b0, 2'b01, 32'h203, 32'h0, 32'hAABB_CCDD, 0, 0, 32'h200, 4'b1100, 32'h0, 32'h0000_AABB};
        run_vec(mv, 11);
`endif

        // DONE held by clk_en=0; a pending load must wait for the exit.
        @(negedge clk);
        data_wr_en_ma = 1'b1; data_addr = 32'h20; data_rd_wr_ctrl = 2'b10; data_wr = 32'h0F0F_0F0F;
        @(negedge clk);
        data_wr_en_ma = 1'b0;
        chk("cke req", {31'b0, mem_req}, 32'd1);
        mem_gnt = 1'b1; clk_en = 1'b0;
        @(negedge clk);
        mem_gnt = 1'b0;
        data_rd_en_ma = 1'b1; data_addr = 32'h24; data_rd_wr_ctrl = 2'b10;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("cke%0d ready_held", k), {31'b0, data_ready}, 32'd1);
            chk($sformatf("cke%0d no_req", k), {31'b0, mem_req}, 32'd0);
            @(negedge clk);
        end
        clk_en = 1'b1;
        #1 chk("cke done_exit_ready", {31'b0, data_ready}, 32'd1);
        @(negedge clk);
        chk("cke idle_accept_ready", {31'b0, data_ready}, 32'd0);
        chk("cke idle_no_req", {31'b0, mem_req}, 32'd0);
        exp_q.push_back(32'h0BAD_CAFE);
        @(negedge clk);
        data_rd_en_ma = 1'b0;
        chk("cke load_req", {31'b0, mem_req}, 32'd1);
        chk("cke load_addr", mem_addr, 32'h24);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0BAD_CAFE;
        @(negedge clk);
        mem_rvalid = 1'b0;
        pop_chk("cke load_data");
        @(negedge clk);

        // Reset during WAIT_R, then a stale rvalid.
        @(negedge clk);
        data_rd_en_ma = 1'b1; data_addr = 32'h300; data_rd_wr_ctrl = 2'b10;
        @(negedge clk);
        data_rd_en_ma = 1'b0; mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        chk("rstw in_wait", {31'b0, data_ready}, 32'd0);
        rst = 1'b1;
        #1;
        chk("rstw mem_req", {31'b0, mem_req}, 32'd0);
        chk("rstw ready", {31'b0, data_ready}, 32'd1);
        chk("rstw data_rd", data_rd, 32'd0);
        @(negedge clk);
        rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h55AA_55AA;
        @(negedge clk);
        mem_rvalid = 1'b0;
        chk("rstw late_rvalid data_rd", data_rd, 32'd0);
        chk("rstw late_rvalid mem_req", {31'b0, mem_req}, 32'd0);
        chk("rstw idle_ready", {31'b0, data_ready}, 32'd1);
        @(negedge clk);
        chk("rstw still_zero", data_rd, 32'd0);

        chk("scoreboard drained", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
